// File: rtl/addern_mp_seq.sv
// Multi-precision adder sequencer: feeds an external n-bit addern one slice per cycle, LSB first.
// Latency WORDS cycles accept->out_valid; result held in DONE until out_ready, in_ready only in IDLE.
module addern_mp_seq #(
  parameter int n     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [n*WORDS-1:0]   a_in,
  input  logic [n*WORDS-1:0]   b_in,
  input  logic                 cin,
  output logic [n-1:0]         add_x,
  output logic [n-1:0]         add_y,
  output logic                 add_cin,
  input  logic [n-1:0]         add_s,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [n*WORDS-1:0]   sum_out,
  output logic                 cout_out
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [WORDS-1:0][n-1:0] wide_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          carry_q, carry_d;
  wide_t         a_q,     a_d;
  wide_t         b_q,     b_d;
  wide_t         sum_q,   sum_d;
  logic          cout_q,  cout_d;

  always_ff @(posedge clk or negedge sreset) begin
    if (!sreset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = wide_t'(a_in);
          b_d     = wide_t'(b_in);
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The addern output is combinational on registered slices, so it is captured every RUN edge.
        sum_d[idx_q] = add_s;
        carry_d      = add_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Slice buses are quiet outside RUN so the attached adder sees zeros while idle.
  assign add_x   = (state_q == RUN) ? a_q[idx_q] : '0;
  assign add_y   = (state_q == RUN) ? b_q[idx_q] : '0;
  assign add_cin = (state_q == RUN) ? carry_q    : 1'b0;

  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: doc/addern_mp_seq.md
ADDERN_MP_SEQ -- requirements
Module: addern_mp_seq

Interface
REQ-001 SHALL have parameter n, default 16: slice width, equal to the n of the attached addern instance.
REQ-002 SHALL have parameter WORDS, default 4: slices per operand, legal range 1..16.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port sreset, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand request.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a_in, input, n*WORDS: operand A.
REQ-008 SHALL have port b_in, input, n*WORDS: operand B.
REQ-009 SHALL have port cin, input, 1: initial carry-in.
REQ-010 SHALL have port add_x, output, n: X slice to addern.
REQ-011 SHALL have port add_y, output, n: Y slice to addern.
REQ-012 SHALL have port add_cin, output, 1: carryin to addern.
REQ-013 SHALL have port add_s, input, n: S from addern (combinational).
REQ-014 SHALL have port add_cout, input, 1: carryout from addern.
REQ-015 SHALL have port out_valid, output, 1: result available.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-017 SHALL have port sum_out, output, n*WORDS: wide sum.
REQ-018 SHALL have port cout_out, output, 1: final carry out of MSB slice.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-020 IDLE: on in_valid&in_ready at a rising edge, SHALL register a_in, b_in; set carry register=cin, slice index=0, sum register=0; go RUN.
REQ-021 RUN: add_x/add_y SHALL be slice [idx*n +: n] of registered A/B; add_cin SHALL equal the carry register; all driven from registers only.
REQ-022 RUN, each edge: sum slice idx <= add_s; carry register <= add_cout; idx <= idx+1.
REQ-023 RUN with idx==WORDS-1: SHALL additionally load cout_out <= add_cout and go DONE; RUN lasts exactly WORDS cycles.
REQ-024 Latency: out_valid SHALL rise WORDS cycles after the accept edge; WORDS=1 gives a one-cycle RUN.
REQ-025 Outside RUN, add_x, add_y, add_cin SHALL be 0.
REQ-026 DONE: sum_out and cout_out SHALL hold stable until out_valid&out_ready at an edge, then go IDLE.
REQ-027 in_valid SHALL be ignored in RUN and DONE; no accept in the same cycle as the result handshake (in_ready rises the cycle after).
REQ-028 sum_out/cout_out SHALL keep the last result in IDLE until the next accept clears them.
REQ-029 Arithmetic SHALL be modulo 2^(n*WORDS); overflow reported only via cout_out.

Reset
REQ-030 sreset low SHALL asynchronously force state IDLE, idx 0, carry 0, operand and sum registers 0, cout_out 0, out_valid 0; in_ready=1 while in reset.
REQ-031 Reset asserted in RUN or DONE SHALL abort the transaction with no result presented; operation resumes on first edge after sreset deasserts.

Verification (n=16, WORDS=4, real addern attached)
REQ-032 a=0x0000_0000_0000_0005, b=0x0000_0000_0000_0002, cin=0 -> sum_out=0x0000_0000_0000_0007, cout_out=0, out_valid 4 cycles after accept.
REQ-033 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> add_cin=1 in all 4 RUN cycles, sum_out=0, cout_out=1.
REQ-034 a=b=0x8000_0000_0000_0000, cin=0, out_ready held low 3 cycles in DONE with in_valid high -> out_valid, sum_out=0, cout_out=1 stable; in_ready=0; no new accept.
REQ-035 Back-to-back: out_ready=1 and in_valid=1 in DONE -> handshake, IDLE next cycle with in_ready=1, accept at following edge, second result correct.
REQ-036 sreset low during RUN cycle 2 -> all outputs 0 immediately, in_ready=1; next transaction 0x1234+0x0001 -> 0x1235, cout_out=0.
